// File: rtl/sha1_arbiter_pkg.sv
// sha1_arbiter_pkg: shared SHA-1 widths, FSM state codes and default timeout
package sha1_arbiter_pkg;
    localparam int SHA1_BLOCK_W           = 512;
    localparam int SHA1_DIGEST_W          = 160;
    localparam int DEFAULT_TIMEOUT_CYCLES = 512;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;
endpackage

// File: rtl/sha1_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first requester after the last grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);
    // scan from farthest to nearest so the nearest requester after last wins
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = req[ID_W'((int'(last) + k) % NUM_REQ)] ? ID_W'((int'(last) + k) % NUM_REQ) : idx;
        end
        any   = |req;
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/sha1_arbiter.sv
// sha1_arbiter: shares one sha1 core among several requesters, one block at a time
module sha1_arbiter
    import sha1_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*SHA1_BLOCK_W-1:0] req_message,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [ID_W-1:0]               resp_id,
    output logic [SHA1_DIGEST_W-1:0]      resp_digest,
    output logic                          resp_error,
    input  logic                          resp_ready,
    output logic                          core_reset,
    output logic                          core_on,
    output logic [SHA1_BLOCK_W-1:0]       core_message,
    input  logic                          core_finish,
    input  logic [SHA1_DIGEST_W:0]        core_digest,
    output logic                          busy
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state;
    logic [ID_W-1:0]         last;
    logic [ID_W-1:0]         win_idx;
    logic [NUM_REQ-1:0]      grant;
    logic                    any_req;
    logic [CNT_W-1:0]        cnt;
    logic [SHA1_BLOCK_W-1:0] win_msg;
    logic                    timeout;
    logic                    unused_digest_msb;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req  (req_valid),
        .last (last),
        .grant(grant),
        .idx  (win_idx),
        .any  (any_req)
    );

    // pick the winner's block out of the flattened request bus
    always_comb begin
        win_msg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_msg = grant[i] ? req_message[i*SHA1_BLOCK_W +: SHA1_BLOCK_W] : win_msg;
        end
    end

    // grants are only offered while idle and never while reset is held
    assign req_ready  = (!reset && state == ST_IDLE) ? grant : '0;
    assign resp_valid = state == ST_RESP;
    assign busy       = state != ST_IDLE;
    assign core_reset = reset || state == ST_CLEAR;
    assign core_on    = state == ST_START || state == ST_WAIT;
    assign timeout    = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    // the top bit of the raw core output carries no digest data
    assign unused_digest_msb = core_digest[SHA1_DIGEST_W];

    // transaction sequencing: arbitrate, clear core, start, wait/timeout, respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            last         <= ID_W'(NUM_REQ - 1);
            resp_id      <= '0;
            resp_digest  <= '0;
            resp_error   <= 1'b0;
            core_message <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: if (any_req) begin
                    state        <= ST_CLEAR;
                    last         <= win_idx;
                    resp_id      <= win_idx;
                    core_message <= win_msg;
                end
                ST_CLEAR: state <= ST_START;
                ST_START: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    cnt <= (cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
                    if (core_finish) begin
                        state       <= ST_RESP;
                        resp_digest <= core_digest[SHA1_DIGEST_W-1:0];
                        resp_error  <= 1'b0;
                    end else if (timeout) begin
                        state       <= ST_RESP;
                        resp_digest <= '0;
                        resp_error  <= 1'b1;
                    end
                end
                ST_RESP: if (resp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_arbiter.sv
// tb_sha1_arbiter: directed transactions checked against a transaction-level model
module tb_sha1_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 512;
    localparam logic [511:0] ABC_MSG = {32'h61626380, 416'h0, 64'h18};
    localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*512-1:0] req_message;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic [IW-1:0]    resp_id;
    logic [159:0]     resp_digest;
    logic             resp_error;
    logic             resp_ready = 1'b0;
    logic             core_reset;
    logic             core_on;
    logic [511:0]     core_message;
    logic             core_finish = 1'b0;
    logic [160:0]     core_digest = '0;
    logic             busy;
    logic [511:0]     msgs [N];

    int checks = 0;
    int passes = 0;

    sha1_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_message(req_message),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_digest(resp_digest), .resp_error(resp_error), .resp_ready(resp_ready),
        .core_reset(core_reset), .core_on(core_on), .core_message(core_message),
        .core_finish(core_finish), .core_digest(core_digest), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[IW'((last + k) % N)]) return (last + k) % N;
        return -1;
    endfunction

    // model: cycle t after acceptance -> 1 clear, 2 start, 3.. wait, then response
    int           m_last = N - 1;
    int           m_t = 0;
    int           m_id = 0;
    int           w;
    logic         m_busy = 1'b0;
    logic         m_resp = 1'b0;
    logic         m_err = 1'b0;
    logic [159:0] m_dig = '0;
    logic [511:0] m_msg = '0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_ready", 512'(req_ready), '0);
            chk("rst_resp_valid", 512'(resp_valid), '0);
            chk("rst_resp_id", 512'(resp_id), '0);
            chk("rst_resp_digest", 512'(resp_digest), '0);
            chk("rst_resp_error", 512'(resp_error), '0);
            chk("rst_core_on", 512'(core_on), '0);
            chk("rst_core_message", core_message, '0);
            chk("rst_busy", 512'(busy), '0);
            chk("rst_core_reset", 512'(core_reset), 512'(1'b1));
            m_busy = 1'b0;
            m_last = N - 1;
        end else if (!m_busy) begin
            w = rr_pick(req_valid, m_last);
            chk("idle_req_ready", 512'(req_ready), w < 0 ? '0 : (512'(1) << w));
            chk("idle_busy", 512'(busy), '0);
            chk("idle_resp_valid", 512'(resp_valid), '0);
            chk("idle_core_ctl", 512'({core_reset, core_on}), '0);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_resp = 1'b0;
                m_t    = 1;
                m_last = w;
                m_id   = w;
                m_msg  = msgs[IW'(w)];
            end
        end else begin
            chk("busy", 512'(busy), 512'(1'b1));
            chk("busy_req_ready", 512'(req_ready), '0);
            chk("core_message", core_message, m_msg);
            chk("core_reset", 512'(core_reset), 512'(m_t == 1));
            chk("core_on", 512'(core_on), 512'(m_t >= 2 && !m_resp));
            chk("resp_valid", 512'(resp_valid), 512'(m_resp));
            if (m_resp) begin
                chk("resp_id", 512'(resp_id), 512'(m_id));
                chk("resp_digest", 512'(resp_digest), 512'(m_dig));
                chk("resp_error", 512'(resp_error), 512'(m_err));
                if (resp_ready) m_busy = 1'b0;
            end else if (m_t >= 3) begin
                if (core_finish) begin
                    m_resp = 1'b1;
                    m_err  = 1'b0;
                    m_dig  = core_digest[159:0];
                end else if (m_t - 3 == TO - 1) begin
                    m_resp = 1'b1;
                    m_err  = 1'b1;
                    m_dig  = '0;
                end
            end
            m_t++;
        end
    end

    // drives one request and plays the core; fin is the WAIT cycle index to finish on (-1: never)
    task automatic run_txn(input logic [N-1:0] v, input int fin, input int hold, input bit keep,
                           input logic [159:0] dg, output int id, output logic [159:0] dig,
                           output logic err, output int wcyc, output logic [N-1:0] gvec,
                           output int gcnt, output int rcyc, output logic [511:0] cm);
        int n = 0;
        int on_cnt = 0;
        bit done = 1'b0;
        id = -1; dig = '0; err = 1'b0; gvec = '0; gcnt = 0; rcyc = 0; cm = '0;
        req_valid = v; core_digest = {1'b1, dg}; resp_ready = 1'b0; core_finish = 1'b0;
        while (!done && n < 3000) begin
            #1;
            if (req_ready != '0) begin
                gcnt++;
                gvec = req_ready;
            end
            @(posedge clk); #1; n++;
            if (resp_ready) begin
                done = 1'b1;
                resp_ready = 1'b0;
            end else begin
                if (busy && !keep) req_valid = '0;
                if (core_reset) cm = core_message;
                if (core_on) on_cnt++;
                core_finish = core_on && fin >= 0 && on_cnt - 2 == fin;
                if (resp_valid) begin
                    if (rcyc == 0) begin
                        id = int'(resp_id);
                        dig = resp_digest;
                        err = resp_error;
                    end
                    rcyc++;
                    resp_ready = rcyc > hold;
                end
            end
        end
        wcyc = on_cnt - 1;
        chk("txn_completes", 512'(done), 512'(1'b1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int id, wcyc, gc, rc, n, on;
        logic [159:0] dig;
        logic err;
        logic [N-1:0] gv;
        logic [511:0] cm;
        int ids [8];
        int exp_ids [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < N; i++) msgs[i] = {16{32'h1111_0000 + 32'(i)}};
        msgs[2] = ABC_MSG;
        req_message = {msgs[3], msgs[2], msgs[1], msgs[0]};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_txn(4'b0100, 5, 0, 1'b0, ABC_DIG, id, dig, err, wcyc, gv, gc, rc, cm);
        chk("single_grant", 512'(gv), 512'(4'b0100));
        chk("single_grant_cycles", 512'(gc), 512'(1));
        chk("single_core_message", cm, ABC_MSG);
        chk("single_id", 512'(id), 512'(2));
        chk("single_digest", 512'(dig), 512'(ABC_DIG));
        chk("single_error", 512'(err), '0);
        chk("single_wait_cycles", 512'(wcyc), 512'(6));

        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            run_txn(4'b1111, 2, 0, 1'b1, {5{32'hc0de_0000 + 32'(k)}}, id, dig, err, wcyc, gv, gc, rc, cm);
            ids[k] = id;
            chk("fair_digest", 512'(dig), 512'({5{32'hc0de_0000 + 32'(k)}}));
        end
        req_valid = '0;
        for (int k = 0; k < 8; k++) chk("fair_id_order", 512'(ids[k]), 512'(exp_ids[k]));

        run_txn(4'b0001, -1, 0, 1'b0, 160'hdead_beef, id, dig, err, wcyc, gv, gc, rc, cm);
        chk("timeout_error", 512'(err), 512'(1'b1));
        chk("timeout_digest", 512'(dig), '0);
        chk("timeout_wait_cycles", 512'(wcyc), 512'(512));
        run_txn(4'b1000, 3, 0, 1'b0, 160'h1234_5678_9abc, id, dig, err, wcyc, gv, gc, rc, cm);
        chk("after_timeout_id", 512'(id), 512'(3));
        chk("after_timeout_error", 512'(err), '0);
        chk("after_timeout_digest", 512'(dig), 512'(160'h1234_5678_9abc));

        run_txn(4'b1111, 1, 20, 1'b1, 160'h5a5a, id, dig, err, wcyc, gv, gc, rc, cm);
        req_valid = '0;
        chk("bp_resp_cycles", 512'(rc), 512'(21));
        chk("bp_grant_cycles", 512'(gc), 512'(1));
        chk("bp_id", 512'(id), 512'(0));

        run_txn(4'b0100, 511, 0, 1'b0, ABC_DIG, id, dig, err, wcyc, gv, gc, rc, cm);
        chk("tie_error", 512'(err), '0);
        chk("tie_digest", 512'(dig), 512'(ABC_DIG));
        chk("tie_wait_cycles", 512'(wcyc), 512'(512));

        req_valid = 4'b0001;
        n = 0;
        on = 0;
        while (on < 12 && n < 100) begin
            @(posedge clk); #1; n++;
            if (core_on) on++;
        end
        chk("rw_reached_wait10", 512'(on), 512'(12));
        reset = 1'b1;
        #1;
        chk("rw_busy", 512'(busy), '0);
        chk("rw_core_reset", 512'(core_reset), 512'(1'b1));
        chk("rw_core_on", 512'(core_on), '0);
        chk("rw_resp_valid", 512'(resp_valid), '0);
        chk("rw_resp_digest", 512'(resp_digest), '0);
        chk("rw_core_message", core_message, '0);
        req_valid = 4'b0010;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_txn(4'b0010, 4, 0, 1'b0, 160'hfeed, id, dig, err, wcyc, gv, gc, rc, cm);
        chk("rw_regrant", 512'(gv), 512'(4'b0010));
        chk("rw_id", 512'(id), 512'(1));
        chk("rw_digest", 512'(dig), 512'(160'hfeed));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sha1_arbiter.md
SHA1_ARBITER -- requirements
Module: sha1_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one sha1 core.
REQ-002 SHALL have parameter ID_W, default 2: width of requester index, equal to clog2(NUM_REQ).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 512: maximum cycles WAIT may last before an error response.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester request pending.
REQ-007 SHALL have port req_message  in  NUM_REQ*512  per-requester 512-bit block; requester i occupies bits [512*i+511:512*i].
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port resp_valid  out  1  response available.
REQ-010 SHALL have port resp_id  out  ID_W  index of the requester being answered.
REQ-011 SHALL have port resp_digest  out  160  digest result.
REQ-012 SHALL have port resp_error  out  1  response ended in timeout.
REQ-013 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-014 SHALL have port core_reset  out  1  synchronous reset to the sha1 core.
REQ-015 SHALL have port core_on  out  1  start request to the core.
REQ-016 SHALL have port core_message  out  512  block driven to the core.
REQ-017 SHALL have port core_finish  in  1  core done flag.
REQ-018 SHALL have port core_digest  in  161  raw core digest output.
REQ-019 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, START, WAIT, RESP.
REQ-021 IDLE: when any req_valid is high, SHALL assert req_ready for exactly one winner for one cycle, capture its message and index, then go to CLEAR.
REQ-022 Winner SHALL be chosen round-robin: search starts at last granted index + 1 and wraps from NUM_REQ-1 to 0; after reset the last granted index is NUM_REQ-1, so requester 0 has first priority.
REQ-023 CLEAR: core_reset=1 for exactly one cycle, then go to START.
REQ-024 START and WAIT: core_on=1; START lasts one cycle, then go to WAIT.
REQ-025 core_message SHALL hold the captured block unchanged from CLEAR through RESP.
REQ-026 WAIT: core_finish=1 SHALL capture core_digest[159:0] into resp_digest with resp_error=0, then go to RESP.
REQ-027 WAIT SHALL count cycles. If TIMEOUT_CYCLES elapse without core_finish, resp_digest=0 and resp_error=1, then go to RESP.
REQ-028 core_finish and timeout expiring in the same cycle: finish SHALL win.
REQ-029 RESP: resp_valid=1 with resp_id, resp_digest and resp_error stable until resp_ready=1, then return to IDLE; core_on=0.
REQ-030 resp_valid and req_ready SHALL never be high in the same cycle; at most one request is in flight.
REQ-031 req_valid deasserted by a non-winner SHALL have no effect; a winner's req_valid after acceptance SHALL be ignored until the next IDLE arbitration.
REQ-032 The timeout counter SHALL be wide enough to hold TIMEOUT_CYCLES, SHALL clear on entry to WAIT and SHALL not wrap.

Reset
REQ-033 On reset assertion, the block SHALL go to IDLE asynchronously.
REQ-034 Output values during reset: req_ready=0, resp_valid=0, resp_id=0, resp_digest=0, resp_error=0, core_on=0, core_message=0, busy=0.
REQ-035 core_reset SHALL be 1 while reset is asserted, so a mid-operation reset also clears the core.
REQ-036 Reset mid-WAIT or mid-RESP SHALL drop the in-flight request with no response.

Structure
REQ-037 A shared package SHALL hold SHA1_BLOCK_W=512, SHA1_DIGEST_W=160, the state enumeration and the default TIMEOUT_CYCLES.
REQ-038 The round-robin grant logic SHALL be one sub-module, rr_arbiter (request vector + last pointer in, one-hot grant + index out).

Verification
REQ-039 Single request: req_valid=4'b0100 with message "abc" padded block -> req_ready=4'b0100 for one cycle, core_reset pulse, core_on; on core_finish, resp_id=2 and resp_digest=core_digest[159:0].
REQ-040 Fairness: all four req_valid held high for 8 transactions -> resp_id sequence 0,1,2,3,0,1,2,3.
REQ-041 Timeout: core_finish tied 0 -> resp_error=1 and resp_digest=0 exactly 512 WAIT cycles after START; the next request still succeeds.
REQ-042 Backpressure: resp_ready=0 for 20 cycles -> resp_valid and outputs stable, no req_ready pulse; on resp_ready=1, return to IDLE.
REQ-043 Reset mid-WAIT: reset at WAIT cycle 10 -> all outputs at reset values, core_reset=1; after release, pending req 1 is granted first.
REQ-044 Finish and timeout in the same cycle (finish at cycle 512) -> resp_error=0, with the digest captured.
